regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the write-data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, the register-number width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: stall  input  1  when high, no requester is granted.
REQ-007 Port: a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-008 Port: a_reg  input  ADDR_W  requester A destination register.
REQ-009 Port: a_data  input  DATA_W  requester A write data.
REQ-010 Port: a_ready  output  1  requester A granted this cycle.
REQ-011 Port: b_valid, b_reg, b_data, b_ready: same as the A ports, for requester B (load writeback).
REQ-012 Port: RegWrite  output  1  register-file write enable, registered.
REQ-013 Port: WriteReg  output  ADDR_W  register-file write address, registered.
REQ-014 Port: WriteData  output  DATA_W  register-file write data, registered.
REQ-015 Port: wr_count  output  16  count of committed non-zero-register writes.

Function
REQ-016 A grant (x_ready=1) SHALL be combinational from valid, stall and the priority state.
REQ-017 A transfer SHALL occur on a cycle where x_valid=1 and x_ready=1.
REQ-018 At most one of a_ready and b_ready SHALL be high in any cycle.
REQ-019 When stall=1, both a_ready and b_ready SHALL be 0.
REQ-020 The priority state SHALL take one of two values: PRIO_A or PRIO_B.
REQ-021 If only one requester is valid and stall=0, that requester SHALL be granted regardless of priority state.
REQ-022 If both requesters are valid and stall=0, the requester named by the priority state SHALL be granted.
REQ-023 After any grant, the priority state SHALL move to favour the other requester (PRIO_A->PRIO_B after A, PRIO_B->PRIO_A after B).
REQ-024 With no grant, the priority state SHALL hold.
REQ-025 A transfer in cycle N SHALL drive RegWrite=1 with the transferred reg/data in cycle N+1 (latency 1).
REQ-026 With no transfer in cycle N, RegWrite SHALL be 0 in cycle N+1.
REQ-027 WriteReg and WriteData SHALL hold their last values when there is no transfer.
REQ-028 A transfer with reg==0 SHALL be accepted (ready=1) but SHALL produce RegWrite=0 and SHALL NOT increment wr_count.
REQ-029 wr_count SHALL increment by 1 in the cycle RegWrite=1 is registered, and SHALL wrap from 0xFFFF to 0x0000.
REQ-030 Back-to-back transfers to the same register SHALL both be issued in grant order, so the later write wins.
REQ-031 A requester whose valid stays high while not granted SHALL be granted no later than the second non-stalled cycle (no starvation).

Reset
REQ-032 While reset=1: RegWrite=0, WriteReg=0, WriteData=0, wr_count=0, priority state=PRIO_A.
REQ-033 An assertion of reset mid-operation SHALL drop any write that is not yet issued.
REQ-034 In the first edge after reset release, behaviour SHALL be as from the PRIO_A state.

Structure
REQ-035 DATA_W, ADDR_W, ZERO_REG (=0) and the PRIO_A/PRIO_B encoding SHALL reside in the shared package regfile_pkg.
REQ-036 Arbitration SHALL be a sub-module rr_arb2 (valid[1:0], prio -> grant[1:0]).
REQ-037 The output register and wr_count SHALL be in the top-level module.

Verification
REQ-038 Reset, then A only: a_valid=1, a_reg=3, a_data=0xDEADBEEF -> a_ready=1 that cycle; next cycle RegWrite=1, WriteReg=3, WriteData=0xDEADBEEF; wr_count=1.
REQ-039 Both valid for 4 cycles (A reg 1, B reg 2), from PRIO_A -> grants A,B,A,B; RegWrite high 4 consecutive cycles with WriteReg 1,2,1,2.
REQ-040 Both valid, stall=1 for 3 cycles -> no ready, RegWrite=0, priority held; on stall release A is granted first.
REQ-041 A writes reg 0 with 0x55 -> a_ready=1, RegWrite=0 next cycle, wr_count unchanged.
REQ-042 wr_count preset via 65535 writes, one more write -> wr_count=0x0000.
REQ-043 Reset asserted the cycle after a B transfer -> RegWrite=0, WriteReg=0, WriteData=0, wr_count=0; first contended grant after release goes to A.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, zero-register number and priority encoding
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 0;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant logic, purely combinational
module rr_arb2
    import regfile_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    // A lone requester always wins; contention is settled by the priority bit.
    assign grant[0] = valid[0] & (~valid[1] | (prio == PRIO_A));
    assign grant[1] = valid[1] & (~valid[0] | (prio == PRIO_B));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - arbitrates ALU and load writebacks onto one register-file write port
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic [15:0]       wr_count
);

    prio_t             prio;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              xfer;
    logic              do_write;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

    assign req = stall ? 2'b00 : {b_valid, a_valid};

    rr_arb2 u_arb (
        .valid (req),
        .prio  (prio),
        .grant (grant)
    );

    assign a_ready  = grant[0];
    assign b_ready  = grant[1];
    assign xfer     = |grant;
    assign sel_reg  = grant[1] ? b_reg  : a_reg;
    assign sel_data = grant[1] ? b_data : a_data;
    // Writes to the hardwired zero register are consumed but never reach the file.
    assign do_write = xfer && (sel_reg != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            wr_count  <= 16'd0;
            prio      <= PRIO_A;
        end else begin
            RegWrite <= do_write;
            if (xfer) begin
                WriteReg  <= sel_reg;
                WriteData <= sel_data;
            end
            if (do_write) begin
                wr_count <= wr_count + 16'd1;
            end
            if (grant[0]) begin
                prio <= PRIO_B;
            end else if (grant[1]) begin
                prio <= PRIO_A;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        b_ready;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [15:0] wr_count;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .a_valid   (a_valid),
        .a_reg     (a_reg),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_reg     (b_reg),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_reg = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_reg = 5'd0; b_data = 32'd0;
        stall   = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        chk_cnt++; if (RegWrite !== 1'b0)    $display("FAIL reset_regwrite got %b exp 0", RegWrite);    else pass_cnt++;
        chk_cnt++; if (WriteReg !== 5'd0)    $display("FAIL reset_writereg got %0d exp 0", WriteReg);   else pass_cnt++;
        chk_cnt++; if (WriteData !== 32'd0)  $display("FAIL reset_writedata got %h exp 0", WriteData);  else pass_cnt++;
        chk_cnt++; if (wr_count !== 16'd0)   $display("FAIL reset_wr_count got %0d exp 0", wr_count);   else pass_cnt++;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_a_only();
        apply_reset();
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'hDEADBEEF;
        #1;
        chk_cnt++; if (a_ready !== 1'b1) $display("FAIL a_only_a_ready got %b exp 1", a_ready); else pass_cnt++;
        chk_cnt++; if (b_ready !== 1'b0) $display("FAIL a_only_b_ready got %b exp 0", b_ready); else pass_cnt++;
        tick();
        a_valid = 1'b0;
        chk_cnt++; if (RegWrite !== 1'b1)          $display("FAIL a_only_regwrite got %b exp 1", RegWrite);   else pass_cnt++;
        chk_cnt++; if (WriteReg !== 5'd3)          $display("FAIL a_only_writereg got %0d exp 3", WriteReg);  else pass_cnt++;
        chk_cnt++; if (WriteData !== 32'hDEADBEEF) $display("FAIL a_only_writedata got %h exp deadbeef", WriteData); else pass_cnt++;
        chk_cnt++; if (wr_count !== 16'd1)         $display("FAIL a_only_wr_count got %0d exp 1", wr_count);  else pass_cnt++;
        tick();
        chk_cnt++; if (RegWrite !== 1'b0)          $display("FAIL idle_regwrite got %b exp 0", RegWrite);     else pass_cnt++;
        chk_cnt++; if (WriteReg !== 5'd3)          $display("FAIL idle_hold_writereg got %0d exp 3", WriteReg); else pass_cnt++;
        chk_cnt++; if (WriteData !== 32'hDEADBEEF) $display("FAIL idle_hold_writedata got %h exp deadbeef", WriteData); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_grant [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [4:0] exp_reg   [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
        apply_reset();
        a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h1111_0001;
        b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h2222_0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_cnt++; if ({b_ready, a_ready} !== exp_grant[i]) $display("FAIL rr_grant%0d got %b exp %b", i, {b_ready, a_ready}, exp_grant[i]); else pass_cnt++;
            tick();
            chk_cnt++; if (RegWrite !== 1'b1)     $display("FAIL rr_regwrite%0d got %b exp 1", i, RegWrite); else pass_cnt++;
            chk_cnt++; if (WriteReg !== exp_reg[i]) $display("FAIL rr_writereg%0d got %0d exp %0d", i, WriteReg, exp_reg[i]); else pass_cnt++;
        end
        idle_inputs();
        chk_cnt++; if (wr_count !== 16'd4) $display("FAIL rr_wr_count got %0d exp 4", wr_count); else pass_cnt++;
    endtask

    task automatic test_stall();
        apply_reset();
        a_valid = 1'b1; a_reg = 5'd4; a_data = 32'h4;
        b_valid = 1'b1; b_reg = 5'd5; b_data = 32'h5;
        stall   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_cnt++; if ({b_ready, a_ready} !== 2'b00) $display("FAIL stall_ready%0d got %b exp 00", i, {b_ready, a_ready}); else pass_cnt++;
            tick();
            chk_cnt++; if (RegWrite !== 1'b0) $display("FAIL stall_regwrite%0d got %b exp 0", i, RegWrite); else pass_cnt++;
        end
        stall = 1'b0;
        #1;
        chk_cnt++; if ({b_ready, a_ready} !== 2'b01) $display("FAIL stall_release_a got %b exp 01", {b_ready, a_ready}); else pass_cnt++;
        tick();
        stall = 1'b1;
        tick();
        tick();
        stall = 1'b0;
        #1;
        chk_cnt++; if ({b_ready, a_ready} !== 2'b10) $display("FAIL stall_hold_prio_b got %b exp 10", {b_ready, a_ready}); else pass_cnt++;
        tick();
        idle_inputs();
        chk_cnt++; if (WriteReg !== 5'd5) $display("FAIL stall_b_writereg got %0d exp 5", WriteReg); else pass_cnt++;
    endtask

    task automatic test_zero_reg();
        apply_reset();
        a_valid = 1'b1; a_reg = 5'd0; a_data = 32'h55;
        #1;
        chk_cnt++; if (a_ready !== 1'b1) $display("FAIL zero_a_ready got %b exp 1", a_ready); else pass_cnt++;
        tick();
        a_valid = 1'b0;
        chk_cnt++; if (RegWrite !== 1'b0) $display("FAIL zero_regwrite got %b exp 0", RegWrite); else pass_cnt++;
        chk_cnt++; if (wr_count !== 16'd0) $display("FAIL zero_wr_count got %0d exp 0", wr_count); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        a_valid = 1'b1; a_reg = 5'd7; a_data = 32'hAAAA_0001;
        b_valid = 1'b1; b_reg = 5'd7; b_data = 32'hBBBB_0002;
        tick();
        chk_cnt++; if (WriteData !== 32'hAAAA_0001) $display("FAIL b2b_first got %h exp aaaa0001", WriteData); else pass_cnt++;
        tick();
        idle_inputs();
        chk_cnt++; if (WriteData !== 32'hBBBB_0002) $display("FAIL b2b_second got %h exp bbbb0002", WriteData); else pass_cnt++;
        tick();
        chk_cnt++; if (WriteData !== 32'hBBBB_0002) $display("FAIL b2b_last_wins got %h exp bbbb0002", WriteData); else pass_cnt++;
        chk_cnt++; if (wr_count !== 16'd2) $display("FAIL b2b_wr_count got %0d exp 2", wr_count); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        a_valid = 1'b1; a_reg = 5'd6; a_data = 32'h6;
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h1;
        b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h2;
        #1;
        chk_cnt++; if ({b_ready, a_ready} !== 2'b01) $display("FAIL rst_prio_restore got %b exp 01", {b_ready, a_ready}); else pass_cnt++;
        idle_inputs();
        tick();
        b_valid = 1'b1; b_reg = 5'd8; b_data = 32'h8888;
        tick();
        b_valid = 1'b0;
        a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h9999;
        #1;
        reset = 1'b1;
        #1;
        chk_cnt++; if (RegWrite !== 1'b0)   $display("FAIL rst_mid_regwrite got %b exp 0", RegWrite);   else pass_cnt++;
        chk_cnt++; if (WriteReg !== 5'd0)   $display("FAIL rst_mid_writereg got %0d exp 0", WriteReg);  else pass_cnt++;
        chk_cnt++; if (WriteData !== 32'd0) $display("FAIL rst_mid_writedata got %h exp 0", WriteData); else pass_cnt++;
        chk_cnt++; if (wr_count !== 16'd0)  $display("FAIL rst_mid_wr_count got %0d exp 0", wr_count);  else pass_cnt++;
        tick();
        chk_cnt++; if (RegWrite !== 1'b0) $display("FAIL rst_mid_dropped got %b exp 0", RegWrite); else pass_cnt++;
        reset = 1'b0;
        b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h2;
        #1;
        chk_cnt++; if ({b_ready, a_ready} !== 2'b01) $display("FAIL rst_mid_first_grant got %b exp 01", {b_ready, a_ready}); else pass_cnt++;
        tick();
        idle_inputs();
        chk_cnt++; if (WriteReg !== 5'd9) $display("FAIL rst_mid_first_reg got %0d exp 9", WriteReg); else pass_cnt++;
    endtask

    task automatic test_wrap();
        apply_reset();
        a_valid = 1'b1; a_reg = 5'd1; a_data = 32'hC0FFEE;
        repeat (65535) @(posedge clk);
        #1;
        chk_cnt++; if (wr_count !== 16'hFFFF) $display("FAIL wrap_preset got %h exp ffff", wr_count); else pass_cnt++;
        tick();
        idle_inputs();
        chk_cnt++; if (wr_count !== 16'h0000) $display("FAIL wrap_zero got %h exp 0000", wr_count); else pass_cnt++;
        chk_cnt++; if (RegWrite !== 1'b1)     $display("FAIL wrap_regwrite got %b exp 1", RegWrite); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_a_only();
        test_round_robin();
        test_stall();
        test_zero_reg();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
